// File: rtl/tia_scanline_doubler.sv
// rtl/tia_scanline_doubler.sv - TIA two-line buffer, 4x/2x scaler and NTSC palette feeding the DVI stage
module tia_scanline_doubler #(
  parameter int          H_TOTAL     = 858,
  parameter int          V_TOTAL     = 525,
  parameter int          H_IMG_START = 0,
  parameter int          V_IMG_START = 0,
  parameter int          SRC_W       = 160,
  parameter int          SRC_H       = 192,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_data,
  input  logic       wr_last,
  input  logic       wr_frame,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       underflow
);

  localparam logic [10:0] HT     = 11'(H_TOTAL);
  localparam logic [9:0]  VT_END = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X0     = 10'(H_IMG_START + 40);
  localparam logic [9:0]  X_PRE  = 10'(H_IMG_START + 39);
  localparam logic [9:0]  X_LAST = 10'(H_IMG_START + 40 + 4 * SRC_W - 1);
  localparam logic [9:0]  Y0     = 10'(V_IMG_START + 48);
  localparam logic [9:0]  Y_LAST = 10'(V_IMG_START + 48 + 2 * SRC_H - 1);
  localparam logic [7:0]  SW     = 8'(SRC_W);

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] SHOW       = 1'b1;

  // NTSC colour table, index = {hue[3:0], luma[2:0]}
  localparam logic [23:0] PALETTE [128] = '{
    24'h000000, 24'h404040, 24'h6c6c6c, 24'h909090, 24'hb0b0b0, 24'hc8c8c8, 24'hdcdcdc, 24'hececec,
    24'h444400, 24'h646410, 24'h848424, 24'ha0a034, 24'hb8b840, 24'hd0d050, 24'he8e85c, 24'hfcfc68,
    24'h702800, 24'h844414, 24'h985c28, 24'hac783c, 24'hbc8c4c, 24'hcca05c, 24'hdcb468, 24'hecc878,
    24'h841800, 24'h983418, 24'hac5030, 24'hc06848, 24'hd0805c, 24'he09470, 24'heca880, 24'hfcbc94,
    24'h880000, 24'h9c2020, 24'hb03c3c, 24'hc05858, 24'hd07070, 24'he08888, 24'heca0a0, 24'hfcb4b4,
    24'h78005c, 24'h8c2074, 24'ha03c88, 24'hb0589c, 24'hc070b0, 24'hd084c0, 24'hdc9cd0, 24'hecb0e0,
    24'h480078, 24'h602090, 24'h783ca4, 24'h8c58b8, 24'ha070cc, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h140084, 24'h302098, 24'h4c3cac, 24'h6858c0, 24'h7c70d0, 24'h9488e0, 24'ha8a0ec, 24'hbcb4fc,
    24'h000088, 24'h1c209c, 24'h3840b0, 24'h505cc0, 24'h6874d0, 24'h7c8ce0, 24'h90a4ec, 24'ha4b8fc,
    24'h00187c, 24'h1c3890, 24'h3854a8, 24'h5070bc, 24'h6888cc, 24'h7c9cdc, 24'h90b4ec, 24'ha4c8fc,
    24'h002c5c, 24'h1c4c78, 24'h386890, 24'h5084ac, 24'h689cc0, 24'h7cb4d4, 24'h90cce8, 24'ha4e0fc,
    24'h003c2c, 24'h1c5c48, 24'h387c64, 24'h509c80, 24'h68b494, 24'h7cd0ac, 24'h90e4c0, 24'ha4fcd4,
    24'h003c00, 24'h205c20, 24'h407c40, 24'h5c9c5c, 24'h74b474, 24'h8cd08c, 24'ha4e4a4, 24'hb8fcb8,
    24'h143800, 24'h345c1c, 24'h507c38, 24'h6c9850, 24'h84b468, 24'h9ccc7c, 24'hb4e490, 24'hc8fca4,
    24'h2c3000, 24'h4c501c, 24'h687034, 24'h848c4c, 24'h9ca864, 24'hb4c078, 24'hccd488, 24'he0ec9c,
    24'h442800, 24'h644818, 24'h846830, 24'ha08444, 24'hb89c58, 24'hd0b46c, 24'he8cc7c, 24'hfce08c
  };

  // bank bookkeeping
  logic [1:0] full;
  logic [1:0] full_next;
  logic       wbank;
  logic [7:0] wptr;
  logic [7:0] len [2];
  logic [6:0] mem [2][SRC_W];

  // read side
  logic [0:0] state;
  logic       rbank;
  logic       rd_next;
  logic       have_bank;
  logic       claimed;
  logic [6:0] rd_word;
  logic       zero_q;
  logic       pix_on_q;

  logic [10:0] hsum;
  logic [9:0]  la_x;
  logic [9:0]  la_y;
  logic        in_cols, in_rows, odd_line, line_pre, line_end, show;
  logic        start_evt, release_evt, frame_end;
  logic [7:0]  src_px, rd_px;
  logic        wr_fire, wr_in_range;
  logic [7:0]  waddr_px, wptr_next;
  logic [6:0]  pix_idx;

  // Lookahead coordinate two clocks ahead of the DVI position, wrapping line and frame
  always_comb begin
    hsum = {1'b0, hpos} + 11'd2;
    la_x = hsum[9:0];
    la_y = vpos;
    if (hsum >= HT) begin
      la_x = 10'(hsum - HT);
      la_y = (vpos == VT_END) ? 10'd0 : vpos + 10'd1;
    end
  end

  // Window decode and line events on the lookahead coordinate
  always_comb begin
    show        = (state == SHOW);
    in_cols     = (la_x >= X0) && (la_x <= X_LAST);
    in_rows     = (la_y >= Y0) && (la_y <= Y_LAST);
    odd_line    = la_y[0] ^ Y0[0];
    line_pre    = (la_x == X_PRE);
    line_end    = (la_x == X_LAST);
    src_px      = 8'((la_x - X0) >> 2);
    rd_px       = in_cols ? src_px : 8'd0;
    start_evt   = line_pre && in_rows && !odd_line && (show || (la_y == Y0));
    release_evt = show && line_end && in_rows && odd_line && claimed;
    frame_end   = show && line_end && (la_y == Y_LAST);
  end

  // Write pointer handling: wr_frame restarts the line, overlong lines saturate and drop
  always_comb begin
    wr_fire     = wr_valid && wr_ready;
    waddr_px    = wr_frame ? 8'd0 : wptr;
    wr_in_range = (waddr_px < SW);
    wptr_next   = wr_in_range ? waddr_px + 8'd1 : waddr_px;
    full_next   = full;
    if (release_evt) full_next[rbank] = 1'b0;
    if (wr_fire && wr_last) full_next[wbank] = 1'b1;
  end

  assign wr_ready = ~(full[0] & full[1]);

  // Write-side bank state: fill pointer, per-bank line length, FULL flags
  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= 2'b00;
      wbank  <= 1'b0;
      wptr   <= 8'd0;
      len[0] <= 8'd0;
      len[1] <= 8'd0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          len[wbank] <= wptr_next;
          wptr       <= 8'd0;
          wbank      <= ~wbank;
        end else begin
          wptr <= wptr_next;
        end
      end
      full <= full_next;
    end
  end

  // Ping-pong line RAM with registered read
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) mem[wbank][waddr_px] <= wr_data;
    rd_word <= mem[rbank][rd_px];
  end

  // Read FSM: claim a bank at each even line start, release after the odd line, end after the last line
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_FRAME;
      rbank     <= 1'b0;
      rd_next   <= 1'b0;
      have_bank <= 1'b0;
      claimed   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= start_evt && !full[rd_next];
      if (start_evt) begin
        state <= SHOW;
        if (full[rd_next]) begin
          rbank     <= rd_next;
          rd_next   <= ~rd_next;
          have_bank <= 1'b1;
          claimed   <= 1'b1;
        end else begin
          claimed <= 1'b0;
        end
      end
      if (release_evt) claimed <= 1'b0;
      if (frame_end) state <= WAIT_FRAME;
    end
  end

  // Stage 1: window flag and short-line zero fill alongside the RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q   <= 1'b1;
      pix_on_q <= 1'b0;
    end else begin
      zero_q   <= !have_bank || (src_px >= len[rbank]);
      pix_on_q <= show && in_cols && in_rows;
    end
  end

  assign pix_idx = zero_q ? 7'd0 : rd_word;

  // Stage 2: registered palette lookup, border colour outside the window
  always_ff @(posedge clk) begin
    if (reset) begin
      {red, green, blue} <= BORDER_RGB;
    end else if (pix_on_q) begin
      {red, green, blue} <= PALETTE[pix_idx];
    end else begin
      {red, green, blue} <= BORDER_RGB;
    end
  end

endmodule
